mult_top: RTL and testbench
===========================

Name: mult_top

Overview:
- Sequential unsigned shift-add multiplier; the companion of the divider.
- Uses the same start/busy/valid/ov handshake and operand widths, so the two blocks are interchangeable under one controller and one testbench style.
- Product held until next start.
- Built as a controller FSM plus a datapath sub-module.

Parameters:
WIDTH, 10, operand and result width in bits

Ports:
clk    input   1      system clock, rising edge
rst    input   1      synchronous active-high reset
start  input   1      request; sampled only in IDLE or DONE
A      input   WIDTH  multiplicand, unsigned; sampled at the accepting edge
B      input   WIDTH  multiplier, unsigned; sampled at the accepting edge
P      output  WIDTH  low WIDTH bits of A*B
busy   output  1      operation in progress
valid  output  1      P/ov hold the result of the last operation (level)
ov     output  1      full product does not fit in WIDTH bits

Behaviour:
- Reset: rst=1 at a rising clk edge forces the following, regardless of state (including mid-operation):
  - state=IDLE, P=0, ov=0, busy=0, valid=0;
  - internal acc/multiplicand/multiplier/counter cleared.
- State IDLE: busy=0, valid=0.
  - start=1 at edge E0: latch mcand={WIDTH'b0,A} (2*WIDTH bits), mplier=B, acc=0, cnt=0; go CALC.
- State CALC: busy=1, valid=0. Each edge:
  - if mplier[0], acc += mcand (2*WIDTH-bit add, cannot overflow);
  - mcand <<= 1; mplier >>= 1; cnt += 1.
  - The edge that performs iteration cnt=WIDTH-1 (edge E_WIDTH) also registers P=sum[WIDTH-1:0] and ov=|sum[2*WIDTH-1:WIDTH], where sum is that edge's updated acc. Go DONE.
- State DONE: busy=0, valid=1; P/ov stable.
  - start=1: accepted exactly as in IDLE. Next state CALC; valid drops, busy rises; P/ov keep old values until the new completion.
- Latency: fixed. busy=1 after E0 through E_WIDTH; valid=1 after E_WIDTH (WIDTH cycles after the accepting edge, 10 for default).
  - No early termination for zero operands.
- start while busy: ignored, no effect on A/B capture or timing.
- A/B changing during CALC: no effect.
- start held high continuously: back-to-back operations, each new op accepted at the first DONE edge. DONE lasts exactly one cycle per result.
- rst and start both high in the same cycle: rst wins.
- Counter width: clog2(WIDTH)+1 bits; no wrap within one operation.
- Outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package mul_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - default WIDTH constant 10.
- Sub-module mult_datapath: acc/mcand/mplier/cnt registers, adder, P/ov registers.
  - Controls: load, step, capture.
  - Status: last (cnt==WIDTH-1).
- mult_top holds the FSM and busy/valid, and instantiates mult_datapath.

Test Plan:
- rst=1 for 1 cycle, then A=110 (0001101110), B=3, start=1 → busy=1 for 10 cycles; valid=1 at 10th edge after acceptance; P=330, ov=0. Check busy/valid on every cycle.
- A=1023, B=1023 → P=1 (0000000001), ov=1 (full product 1046529).
- A=32, B=32 → P=0, ov=1. A=0, B=1023 → P=0, ov=0, still 10-cycle latency.
- Start A=5, B=7. At cycle 4 pulse start with A=9, B=9 → ignored; result P=35, ov=0, valid at original cycle 10.
- Start A=100, B=10. Assert rst at cycle 5 → next cycle busy=0, valid=0, P=0, ov=0. Then start A=2, B=3 → P=6 after 10 cycles.
- start held high with A=3, B=4 → P=12 valid for exactly one cycle, then busy rises the next cycle. Repeats every 11 cycles; P stays 12.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier.
// Holds the FSM state encoding and default operand width.
package mul_pkg;

  localparam int WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_datapath.sv
// Multiplier datapath: acc/mcand/mplier/cnt, adder, P/ov regs.
// Ports: load/step/capture controls, a/b operands, p/ov/last out.
module mult_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             capture,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             ov,
  output logic             last
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    sum;

  // Updated accumulator for this iteration; also feeds P/ov on
  // the final step so the result lands on the same edge.
  assign sum  = acc + (mplier[0] ? mcand : '0);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
      ov     <= 1'b0;
    end else begin
      if (load) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= '0;
      end else if (step) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (capture) begin
        p  <= sum[WIDTH-1:0];
        ov <= |sum[PW-1:WIDTH];
      end
    end
  end

endmodule

// File: rtl/mult_top.sv
// Sequential unsigned shift-add multiplier, start/busy/valid/ov.
// Ports: clk, rst, start, A, B in; P, busy, valid, ov out.
module mult_top
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] P,
  output logic             busy,
  output logic             valid,
  output logic             ov
);

  state_t state;
  logic   load;
  logic   step;
  logic   capture;
  logic   last;

  // start is only honoured when not computing
  assign load    = start && (state == S_IDLE || state == S_DONE);
  assign step    = (state == S_CALC);
  assign capture = step && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_CALC;
            busy  <= 1'b1;
            valid <= 1'b0;
          end
        end
        S_CALC: begin
          if (last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .capture(capture),
    .a      (A),
    .b      (B),
    .p      (P),
    .ov     (ov),
    .last   (last)
  );

endmodule

// File: tb/tb_mult_top.sv
// Directed bench for mult_top (WIDTH=10).
// Hand-computed products, per-cycle busy/valid checks.
module tb_mult_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] A;
  logic [9:0] B;
  logic [9:0] P;
  logic       busy;
  logic       valid;
  logic       ov;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mult_top #(
    .WIDTH(10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .P    (P),
    .busy (busy),
    .valid(valid),
    .ov   (ov)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge; optionally pulse a stray start
  // with other operands mid-calculation (ign_at > 0).
  task automatic run_op(input logic [9:0] a,
                        input logic [9:0] b,
                        input logic [9:0] ep,
                        input logic       eov,
                        input int         ign_at);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_e0", 32'(busy), 32'd1);
    chk("valid_e0", 32'(valid), 32'd0);
    for (int i = 1; i < 10; i++) begin
      if (ign_at > 0 && i == ign_at) begin
        A = 10'd9;
        B = 10'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("busy_calc", 32'(busy), 32'd1);
      chk("valid_calc", 32'(valid), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("busy_done", 32'(busy), 32'd0);
    chk("valid_done", 32'(valid), 32'd1);
    chk("p", 32'(P), 32'(ep));
    chk("ov", 32'(ov), 32'(eov));
    @(negedge clk);
    chk("valid_hold", 32'(valid), 32'd1);
    chk("p_hold", 32'(P), 32'(ep));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    A = 10'd5;
    B = 10'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_p", 32'(P), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);

    run_op(10'd110, 10'd3, 10'd330, 1'b0, 0);
    run_op(10'd1023, 10'd1023, 10'd1, 1'b1, 0);
    run_op(10'd32, 10'd32, 10'd0, 1'b1, 0);
    run_op(10'd0, 10'd1023, 10'd0, 1'b0, 0);
    run_op(10'd5, 10'd7, 10'd35, 1'b0, 4);
    run_op(10'd31, 10'd33, 10'd1023, 1'b0, 0);
    run_op(10'd32, 10'd31, 10'd992, 1'b0, 0);

    // reset mid-operation
    A = 10'd100;
    B = 10'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(valid), 32'd0);
    chk("mrst_p", 32'(P), 32'd0);
    chk("mrst_ov", 32'(ov), 32'd0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    run_op(10'd2, 10'd3, 10'd6, 1'b0, 0);

    // start held high: period of 11 edges, DONE for one cycle
    A = 10'd3;
    B = 10'd4;
    start = 1'b1;
    for (int j = 0; j < 33; j++) begin
      @(negedge clk);
      if (j % 11 == 10) begin
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_p", 32'(P), 32'd12);
      end else begin
        chk("b2b_valid", 32'(valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        if (j > 10)
          chk("b2b_phold", 32'(P), 32'd12);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
